jtag_master: RTL and testbench
==============================

JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning TCK half-period in clk cycles (legal values 1..255).
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 SHALL have port TRST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_type, input, 2 bits: CMD_RESET, CMD_IR or CMD_DR.
REQ-008 SHALL have port cmd_len, input, 6 bits: shift length; legal values 1..32.
REQ-009 SHALL have port cmd_data, input, 32 bits: TDI payload, shifted LSB first.
REQ-010 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-012 SHALL have port rsp_data, output, 32 bits: captured TDO; bit i holds the i-th shifted bit.
REQ-013 SHALL have port rsp_err, output, 1 bit: illegal cmd_len.
REQ-014 SHALL have port TCK, output, 1 bit: JTAG test clock.
REQ-015 SHALL have port TMS, output, 1 bit: JTAG mode select.
REQ-016 SHALL have port TDI, output, 1 bit: JTAG data in.
REQ-017 SHALL have port TDO, input, 1 bit: JTAG data out from the target.

Function
REQ-018 TCK timing SHALL be as follows:
- TCK period is 2*TCK_DIV clk cycles.
- TCK idles low and toggles only while a TMS/TDI bit is being issued.
REQ-019 TMS and TDI SHALL change only on the clk edge that drives TCK low; TDO SHALL be sampled on the clk edge that drives TCK high.
REQ-020 The FSM SHALL have states INIT_TLR, IDLE, PRE, SHIFT, POST, WAIT and RESP.
REQ-021 Outside INIT_TLR, the modelled TAP SHALL be in Run-Test/Idle whenever the FSM is in IDLE.
REQ-022 cmd_ready SHALL be 1 only in IDLE with rsp_valid=0.
REQ-023 CMD_RESET SHALL issue six TCK pulses with TMS=1,1,1,1,1,0, then go to RESP with rsp_data=0.
REQ-024 The CMD_IR PRE phase SHALL issue TMS=1,1,0,0, reaching Shift-IR.
REQ-025 The CMD_DR PRE phase SHALL issue TMS=1,0,0, reaching Shift-DR.
REQ-026 The SHIFT phase SHALL issue cmd_len pulses:
- TDI=cmd_data[k] on pulse k.
- TMS=0 on every pulse except the last, which has TMS=1 (Exit1).
REQ-027 The POST phase SHALL issue TMS=1 (Update) followed by TMS=0 (Run-Test/Idle).
REQ-028 In RESP, rsp_valid SHALL be 1, holding rsp_data and rsp_err stable until rsp_ready=1; the FSM SHALL return to IDLE on that cycle.
REQ-029 rsp_data bits at and above cmd_len SHALL be 0.
REQ-030 An IR/DR command with cmd_len=0 or cmd_len>32 SHALL produce no TCK activity, rsp_err=1, rsp_data=0 and rsp_valid on the next cycle.
REQ-031 cmd_type=2'b11 SHALL be treated as CMD_RESET.
REQ-032 cmd_data, cmd_len and cmd_type SHALL be registered at acceptance; later input changes have no effect.

Reset
REQ-033 On TRST=1 the outputs SHALL become TCK=0, TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-034 On TRST=1 the FSM SHALL go to INIT_TLR and the divider counter SHALL clear.
REQ-035 TRST SHALL abort any operation in progress mid-shift; no response is produced for the aborted command.
REQ-036 After TRST falls, INIT_TLR SHALL run the CMD_RESET TMS sequence, then enter IDLE with cmd_ready=1.

Configuration
REQ-037 Macro JTAG_MASTER_RTI_WAIT_EN defined: the block SHALL have an input cmd_wait, 8 bits, registered at acceptance.
REQ-038 Macro JTAG_MASTER_RTI_WAIT_EN defined: after POST, WAIT SHALL issue cmd_wait extra TCK pulses with TMS=0 and TDI=0 before RESP; with cmd_wait=0, WAIT is skipped.
REQ-039 Macro JTAG_MASTER_RTI_WAIT_EN undefined: the cmd_wait port and the WAIT state SHALL be absent.

Structure
REQ-040 jtag_types_pkg SHALL hold:
- jtag_cmd_t: CMD_RESET=2'b00, CMD_IR=2'b01, CMD_DR=2'b10.
- jtag_master_state_t.
- constant JTAG_MAX_SHIFT=32.
REQ-041 Sub-module tck_gen SHALL hold the TCK_DIV counter, driving TCK and producing one-cycle tck_rise and tck_fall strobes, enabled by the FSM.

Verification
REQ-042 TCK_DIV=2, TRST pulse then release -> six TCK pulses, TMS=1,1,1,1,1,0, period 4 clk; then cmd_ready=1.
REQ-043 CMD_IR, len=4, data=4'b0010, TDO tied 0 -> TMS=1,1,0,0,0,0,0,1,1,0; TDI during shift=0,1,0,0; rsp_data=0.
REQ-044 CMD_DR, len=8, TDO tied 1 -> rsp_data=32'h000000FF; TMS=1 only on the 8th shift pulse and the Update pulse.
REQ-045 Connect to the jtag top-level, CMD_DR len=32 with BSR selected -> TDI bits reach the BSR; the captured value matches the BSR contents after 32 pulses.
REQ-046 CMD_DR len=0 -> no TCK edge, rsp_err=1; rsp_ready held 0 for 5 cycles -> rsp_valid stays 1 and cmd_ready stays 0.
REQ-047 TRST asserted at shift pulse 3 of 8 -> next cycle reset outputs as REQ-033, no rsp_valid, INIT_TLR sequence rerun.

Source files
------------

// File: rtl/jtag_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_types_pkg
// Description : Shared types and constants for the JTAG master: command
//               encoding, FSM state encoding and TMS sequence lengths.
//               Optional macro JTAG_MASTER_RTI_WAIT_EN adds the WAIT state.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_types_pkg;

   // Longest IR/DR scan the master accepts
   localparam int JTAG_MAX_SHIFT = 32;

   // Pulse counts of the fixed TMS sequences
   localparam int c_tlr_pulses    = 6;  // 1,1,1,1,1,0 : any state -> TLR -> RTI
   localparam int c_ir_pre_pulses = 4;  // 1,1,0,0     : RTI -> Shift-IR
   localparam int c_dr_pre_pulses = 3;  // 1,0,0       : RTI -> Shift-DR
   localparam int c_post_pulses   = 2;  // 1,0         : Exit1 -> Update -> RTI

   typedef enum logic [1:0] {
      CMD_RESET = 2'b00,
      CMD_IR    = 2'b01,
      CMD_DR    = 2'b10
   } jtag_cmd_t;

   typedef enum logic [2:0] {
      INIT_TLR = 3'd0,
      IDLE     = 3'd1,
      PRE      = 3'd2,
      SHIFT    = 3'd3,
      POST     = 3'd4,
`ifdef JTAG_MASTER_RTI_WAIT_EN
      WAIT     = 3'd5,
`endif
      RESP     = 3'd6
   } jtag_master_state_t;

endpackage : jtag_types_pkg
`default_nettype wire

// File: rtl/jtag_master_tck_gen.sv
`default_nettype none
// ============================================================================
// Module      : tck_gen
// Description : TCK divider. While enabled, toggles TCK every TCK_DIV clk
//               cycles starting from low, and flags the clk edge that drives
//               TCK high (o_rise) or low (o_fall). Idles low when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   output logic o_tck,
   output logic o_rise,
   output logic o_fall
);

   localparam logic [7:0] c_div_last = 8'(TCK_DIV - 1);

   logic [7:0] r_cnt;
   logic       r_tck;
   logic       w_wrap;

   assign w_wrap = i_en && (r_cnt == c_div_last);
   assign o_rise = w_wrap && !r_tck;
   assign o_fall = w_wrap && r_tck;
   assign o_tck  = r_tck;

   // Half-period counter; TCK toggles when the counter wraps
   always_ff @(posedge clk) begin
      if (rst || !i_en) begin
         r_cnt <= 8'd0;
         r_tck <= 1'b0;
      end else if (r_cnt == c_div_last) begin
         r_cnt <= 8'd0;
         r_tck <= ~r_tck;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule : tck_gen
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : jtag_master
// Description : Command-driven JTAG master. Accepts RESET / IR-scan / DR-scan
//               commands, walks the TAP from Run-Test/Idle through the shift
//               state and back, and returns the captured TDO bits.
//               Optional macro JTAG_MASTER_RTI_WAIT_EN adds cmd_wait and
//               extra Run-Test/Idle clocks after each scan.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_master
   import jtag_types_pkg::*;
#(
   parameter int TCK_DIV = 2
) (
   input  logic        clk,
   input  logic        TRST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [5:0]  cmd_len,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        TCK,
   output logic        TMS,
   output logic        TDI,
   input  logic        TDO
`ifdef JTAG_MASTER_RTI_WAIT_EN
   ,
   input  logic [7:0]  cmd_wait
`endif
);

   jtag_master_state_t r_state;
   jtag_master_state_t w_state_nxt;

   logic [7:0]  r_bit;        // pulse index inside the current phase
   logic        r_is_ir;
   logic        r_from_cmd;   // INIT_TLR entered by a CMD_RESET, not by TRST
   logic [5:0]  r_len;
   logic [31:0] r_data;
   logic [31:0] r_cap;
   logic        r_err;
`ifdef JTAG_MASTER_RTI_WAIT_EN
   logic [7:0]  r_wait;
`endif

   logic        w_en;
   logic        w_rise;
   logic        w_fall;
   logic        w_last;
   logic        w_tms;
   logic        w_tdi;
   logic        w_tck;
   logic        w_accept;
   logic        w_scan;
   logic        w_len_bad;
   logic [7:0]  w_shift_last;

   assign w_accept     = (r_state == IDLE) && cmd_valid;
   assign w_scan       = (cmd_type == CMD_IR) || (cmd_type == CMD_DR);
   assign w_len_bad    = (cmd_len == 6'd0) || (cmd_len > 6'(JTAG_MAX_SHIFT));
   assign w_shift_last = {2'b00, r_len} - 8'd1;

   tck_gen #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_gen (
      .clk    (clk),
      .rst    (TRST),
      .i_en   (w_en),
      .o_tck  (w_tck),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   // FSM state register; TRST restarts the TAP reset sequence
   always_ff @(posedge clk) begin
      if (TRST) begin
         r_state <= INIT_TLR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: phases advance on the TCK falling edge of their last pulse
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               if (w_scan) begin
                  w_state_nxt = w_len_bad ? RESP : PRE;
               end else begin
                  w_state_nxt = INIT_TLR;
               end
            end
         end
         INIT_TLR: begin
            if (w_fall && w_last) begin
               w_state_nxt = r_from_cmd ? RESP : IDLE;
            end
         end
         PRE: begin
            if (w_fall && w_last) begin
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (w_fall && w_last) begin
               w_state_nxt = POST;
            end
         end
         POST: begin
            if (w_fall && w_last) begin
`ifdef JTAG_MASTER_RTI_WAIT_EN
               w_state_nxt = (r_wait != 8'd0) ? WAIT : RESP;
`else
               w_state_nxt = RESP;
`endif
            end
         end
`ifdef JTAG_MASTER_RTI_WAIT_EN
         WAIT: begin
            if (w_fall && w_last) begin
               w_state_nxt = RESP;
            end
         end
`endif
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = INIT_TLR;
      endcase
   end

   // Output decode: TMS/TDI of the current pulse, TCK enable, last-pulse flag
   always_comb begin
      w_en   = 1'b0;
      w_tms  = 1'b0;
      w_tdi  = 1'b0;
      w_last = 1'b0;
      case (r_state)
         INIT_TLR: begin
            w_en   = 1'b1;
            w_tms  = (r_bit < 8'(c_tlr_pulses - 1));
            w_last = (r_bit == 8'(c_tlr_pulses - 1));
         end
         PRE: begin
            w_en = 1'b1;
            if (r_is_ir) begin
               w_tms  = (r_bit < 8'd2);
               w_last = (r_bit == 8'(c_ir_pre_pulses - 1));
            end else begin
               w_tms  = (r_bit == 8'd0);
               w_last = (r_bit == 8'(c_dr_pre_pulses - 1));
            end
         end
         SHIFT: begin
            w_en   = 1'b1;
            w_last = (r_bit == w_shift_last);
            w_tms  = w_last;                 // last bit moves to Exit1
            w_tdi  = r_data[r_bit[4:0]];
         end
         POST: begin
            w_en   = 1'b1;
            w_tms  = (r_bit == 8'd0);
            w_last = (r_bit == 8'(c_post_pulses - 1));
         end
`ifdef JTAG_MASTER_RTI_WAIT_EN
         WAIT: begin
            w_en   = 1'b1;
            w_last = (r_bit == (r_wait - 8'd1));
         end
`endif
         default: ;
      endcase
   end

   // Command capture, pulse counter and TDO capture
   always_ff @(posedge clk) begin
      if (TRST) begin
         r_bit      <= 8'd0;
         r_is_ir    <= 1'b0;
         r_from_cmd <= 1'b0;
         r_len      <= 6'd0;
         r_data     <= 32'd0;
         r_cap      <= 32'd0;
         r_err      <= 1'b0;
`ifdef JTAG_MASTER_RTI_WAIT_EN
         r_wait     <= 8'd0;
`endif
      end else begin
         if (w_accept) begin
            r_bit      <= 8'd0;
            r_is_ir    <= (cmd_type == CMD_IR);
            r_from_cmd <= !w_scan;
            r_len      <= cmd_len;
            r_data     <= cmd_data;
            r_cap      <= 32'd0;
            r_err      <= w_scan && w_len_bad;
`ifdef JTAG_MASTER_RTI_WAIT_EN
            r_wait     <= cmd_wait;
`endif
         end else if (w_fall) begin
            r_bit <= w_last ? 8'd0 : (r_bit + 8'd1);
         end
         if ((r_state == SHIFT) && w_rise) begin
            r_cap[r_bit[4:0]] <= TDO;
         end
      end
   end

   assign cmd_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_cap;
   assign rsp_err   = r_err;
   assign TCK       = w_tck;
   assign TMS       = w_tms;
   assign TDI       = w_tdi;

endmodule : jtag_master
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_master
// Description : Self-checking bench for jtag_master (TCK_DIV=2) with a
//               behavioural TAP / boundary-scan target model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_master;
   import jtag_types_pkg::*;

   logic        clk = 1'b0;
   logic        TRST;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_type;
   logic [5:0]  cmd_len;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        TCK;
   logic        TMS;
   logic        TDI;
   logic        TDO;
   logic [1:0]  tdo_mode;    // 0: tied 0, 1: tied 1, 2: TAP model
   logic        tdo_model;

   always #5 clk = ~clk;

   assign TDO = (tdo_mode == 2'd0) ? 1'b0 : (tdo_mode == 2'd1) ? 1'b1 : tdo_model;

   jtag_master #(.TCK_DIV(2)) dut (
      .clk       (clk),
      .TRST      (TRST),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_type  (cmd_type),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .TCK       (TCK),
      .TMS       (TMS),
      .TDI       (TDI),
      .TDO       (TDO)
`ifdef JTAG_MASTER_RTI_WAIT_EN
      ,
      .cmd_wait  (8'd0)
`endif
   );

   // ---------------- TAP target model with a 32-bit BSR ----------------
   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PSDR, T_EX2DR, T_UPDR,
      T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PSIR, T_EX2IR, T_UPIR
   } tap_t;

   tap_t        tap    = T_TLR;
   logic [31:0] dr_sr  = 32'd0;
   logic [31:0] bsr    = 32'hCAFE_F00D;
   logic [3:0]  ir_sr  = 4'd0;
   logic [3:0]  ir_reg = 4'd0;

   assign tdo_model = (tap == T_SHDR) ? dr_sr[0] : (tap == T_SHIR) ? ir_sr[0] : 1'b0;

   always @(posedge TCK) begin
      case (tap)
         T_CAPDR: dr_sr  <= bsr;
         T_SHDR:  dr_sr  <= {TDI, dr_sr[31:1]};
         T_UPDR:  bsr    <= dr_sr;
         T_CAPIR: ir_sr  <= 4'b0001;
         T_SHIR:  ir_sr  <= {TDI, ir_sr[3:1]};
         T_UPIR:  ir_reg <= ir_sr;
         default: ;
      endcase
      case (tap)
         T_TLR:   tap <= TMS ? T_TLR   : T_RTI;
         T_RTI:   tap <= TMS ? T_SELDR : T_RTI;
         T_SELDR: tap <= TMS ? T_SELIR : T_CAPDR;
         T_CAPDR: tap <= TMS ? T_EX1DR : T_SHDR;
         T_SHDR:  tap <= TMS ? T_EX1DR : T_SHDR;
         T_EX1DR: tap <= TMS ? T_UPDR  : T_PSDR;
         T_PSDR:  tap <= TMS ? T_EX2DR : T_PSDR;
         T_EX2DR: tap <= TMS ? T_UPDR  : T_SHDR;
         T_UPDR:  tap <= TMS ? T_SELDR : T_RTI;
         T_SELIR: tap <= TMS ? T_TLR   : T_CAPIR;
         T_CAPIR: tap <= TMS ? T_EX1IR : T_SHIR;
         T_SHIR:  tap <= TMS ? T_EX1IR : T_SHIR;
         T_EX1IR: tap <= TMS ? T_UPIR  : T_PSIR;
         T_PSIR:  tap <= TMS ? T_EX2IR : T_PSIR;
         T_EX2IR: tap <= TMS ? T_UPIR  : T_SHIR;
         default: tap <= TMS ? T_SELDR : T_RTI;   // T_UPIR
      endcase
   end

   // ---------------- pulse monitor and scoreboard ----------------
   logic [1:0]  obs_q[$];      // {TMS,TDI} seen at each TCK rise
   time         rise_t[$];
   logic [1:0]  exp_q[$];

   always @(posedge TCK) begin
      obs_q.push_back({TMS, TDI});
      rise_t.push_back($time);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected TMS/TDI per pulse, derived from the command description
   task automatic push_pulses(input logic [1:0] t, input int len, input logic [31:0] d);
      if ((t == 2'b01) || (t == 2'b10)) begin
         if ((len < 1) || (len > 32)) return;
         if (t == 2'b01) begin
            exp_q.push_back(2'b10); exp_q.push_back(2'b10);
            exp_q.push_back(2'b00); exp_q.push_back(2'b00);
         end else begin
            exp_q.push_back(2'b10); exp_q.push_back(2'b00); exp_q.push_back(2'b00);
         end
         for (int k = 0; k < len; k++) exp_q.push_back({1'(k == len - 1), d[k]});
         exp_q.push_back(2'b10);
         exp_q.push_back(2'b00);
      end else begin
         for (int k = 0; k < 6; k++) exp_q.push_back({1'(k < 5), 1'b0});
      end
   endtask

   task automatic check_pulses(input string tag);
      logic [1:0] e;
      logic [1:0] o;
      chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      while ((exp_q.size() > 0) && (obs_q.size() > 0)) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk({tag, "_tms_tdi"}, 64'(o), 64'(e));
      end
      for (int i = 1; i < rise_t.size(); i++)
         chk({tag, "_period"}, 64'(rise_t[i] - rise_t[i-1]), 64'd40);
      obs_q.delete();
      exp_q.delete();
      rise_t.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tck"},   64'(TCK),       64'd0);
      chk({tag, "_tms"},   64'(TMS),       64'd1);
      chk({tag, "_tdi"},   64'(TDI),       64'd0);
      chk({tag, "_ready"}, 64'(cmd_ready), 64'd0);
      chk({tag, "_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_data"},  64'(rsp_data),  64'd0);
      chk({tag, "_err"},   64'(rsp_err),   64'd0);
   endtask

   // Full command: handshake, scramble inputs after acceptance, await response
   task automatic run_cmd(input string tag, input logic [1:0] t, input logic [5:0] len,
                          input logic [31:0] d, input logic [32:0] exp_rsp);
      int n;
      push_pulses(t, int'(len), d);
      cmd_type  = t;
      cmd_len   = len;
      cmd_data  = d;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && (n < 200)) begin tick(); n++; end
      chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      cmd_type  = ~t;
      cmd_len   = 6'd17;
      cmd_data  = ~d;
      n = 0;
      while (!rsp_valid && (n < 2000)) begin tick(); n++; end
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_rsp"}, 64'({rsp_err, rsp_data}), 64'(exp_rsp));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
      check_pulses(tag);
   endtask

   initial begin : stim
      int n;
      int seen;
      TRST      = 1'b1;
      cmd_valid = 1'b0;
      cmd_type  = 2'b00;
      cmd_len   = 6'd0;
      cmd_data  = 32'd0;
      rsp_ready = 1'b0;
      tdo_mode  = 2'd0;
      repeat (3) tick();
      check_reset_outputs("reset");
      obs_q.delete();
      rise_t.delete();

      // Power-up TLR sequence
      push_pulses(2'b00, 6, 32'd0);
      TRST = 1'b0;
      n = 0;
      while (!cmd_ready && (n < 200)) begin tick(); n++; end
      chk("init_ready", 64'(cmd_ready), 64'd1);
      check_pulses("init");
      chk("init_tap", 64'(tap), 64'(T_RTI));

      // IR scan, TDO tied 0
      tdo_mode = 2'd0;
      run_cmd("ir4", 2'b01, 6'd4, 32'h0000_0002, {1'b0, 32'h0});
      chk("ir4_tap", 64'(tap), 64'(T_RTI));
      chk("ir4_ir", 64'(ir_reg), 64'h2);

      // DR scan, TDO tied 1
      tdo_mode = 2'd1;
      run_cmd("dr8", 2'b10, 6'd8, 32'h0000_00A5, {1'b0, 32'h0000_00FF});
      chk("dr8_bsr", 64'(bsr), 64'hA5CA_FEF0);

      // Target-driven TDO: IR capture pattern, then two full-width DR scans
      tdo_mode = 2'd2;
      run_cmd("ir_cap", 2'b01, 6'd4, 32'h0000_0005, {1'b0, 32'h0000_0001});
      chk("ir_cap_ir", 64'(ir_reg), 64'h5);
      run_cmd("dr32a", 2'b10, 6'd32, 32'h1234_5678, {1'b0, 32'hA5CA_FEF0});
      chk("dr32a_bsr", 64'(bsr), 64'h1234_5678);
      run_cmd("dr32b", 2'b10, 6'd32, 32'hDEAD_BEEF, {1'b0, 32'h1234_5678});
      chk("dr32b_bsr", 64'(bsr), 64'hDEAD_BEEF);
      chk("dr32b_tap", 64'(tap), 64'(T_RTI));

      // Illegal length 0: immediate error response, held while rsp_ready low
      cmd_type  = 2'b10;
      cmd_len   = 6'd0;
      cmd_data  = 32'hFFFF_FFFF;
      cmd_valid = 1'b1;
      chk("len0_ready", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      chk("len0_rsp", 64'({rsp_valid, rsp_err, rsp_data}), {31'd0, 1'b1, 1'b1, 32'd0});
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("len0_hold", 64'({rsp_valid, cmd_ready, rsp_err}), 64'b101);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_pulses("len0");

      // Illegal length 33 on IR
      run_cmd("len33", 2'b01, 6'd33, 32'hFFFF_FFFF, {1'b1, 32'h0});

      // cmd_type 2'b11 acts as CMD_RESET
      run_cmd("rst11", 2'b11, 6'd5, 32'hFFFF_FFFF, {1'b0, 32'h0});
      chk("rst11_tap", 64'(tap), 64'(T_RTI));

      // TRST during the third of eight shift pulses
      tdo_mode  = 2'd1;
      cmd_type  = 2'b10;
      cmd_len   = 6'd8;
      cmd_data  = 32'h0000_00FF;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while ((obs_q.size() < 6) && (n < 200)) begin tick(); n++; end
      chk("abort_reached", 64'(obs_q.size()), 64'd6);
      TRST = 1'b1;
      tick();
      check_reset_outputs("abort");
      obs_q.delete();
      rise_t.delete();
      exp_q.delete();
      tick();
      push_pulses(2'b00, 6, 32'd0);
      TRST = 1'b0;
      n    = 0;
      seen = 0;
      while (!cmd_ready && (n < 300)) begin
         tick();
         if (rsp_valid) seen++;
         n++;
      end
      chk("abort_no_rsp", 64'(seen), 64'd0);
      chk("abort_ready", 64'(cmd_ready), 64'd1);
      check_pulses("abort_init");
      chk("abort_tap", 64'(tap), 64'(T_RTI));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_jtag_master
`default_nettype wire
